occ_block_fetch: RTL
====================

Name: occ_block_fetch

Overview:
- Upstream feeder for the occurrence decompressor in the BWT extend path.
- Accepts a BWT position k and applies the primary-index adjustment.
- Reads the 256-bit occurrence block containing k from memory, or reuses it from a one-entry block cache.
- Drives the decompressor with block and in-block offset, captures its four 40-bit counts, and returns them with the request tag.

Parameters:
- ADDR_W, 64, memory byte-address width.
- TAG_W, 8, request tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_primary  in  40  BWT primary index; stable while busy.
- cfg_bwt_base  in  ADDR_W  byte address of occ block 0; 32-byte aligned.
- cache_inv  in  1  pulse; invalidates the block cache.
- req_valid  in  1  request handshake.
- req_ready  out  1  request handshake.
- req_k  in  40  BWT position; all-ones encodes -1.
- req_tag  in  TAG_W  opaque tag.
- mem_rd_valid  out  1  read-address handshake.
- mem_rd_ready  in  1  read-address handshake.
- mem_rd_addr  out  ADDR_W  read byte address.
- mem_rsp_valid  in  1  read data valid; no backpressure.
- mem_rsp_data  in  256  occ block.
- dec_block  out  256  block to decompressor.
- dec_i  out  5  offset to decompressor.
- dec_start  out  1  decompressor start.
- dec_busy  in  1  decompressor busy.
- dec_finish  in  1  decompressor finish.
- dec_val  in  4x40  decompressor counts A,C,G,T.
- rsp_valid  out  1  result handshake.
- rsp_ready  in  1  result handshake.
- rsp_occ  out  4x40  occ counts A,C,G,T.
- rsp_tag  out  TAG_W  echoed tag.

Behaviour:
- Reset (async assert, sync release) values: FSM=IDLE, cache_vld=0, req_ready=0 during reset then 1 in IDLE, mem_rd_valid=0, mem_rd_addr=0, dec_start=0, dec_block=0, dec_i=0, rsp_valid=0, rsp_occ=0, rsp_tag=0.
- Reset mid-operation aborts the transaction without a response. A memory response in flight at reset is the memory side's responsibility; the block ignores mem_rsp_valid outside WAIT_RSP.
- Adjustment: kk = k - (k >= cfg_primary), 40-bit unsigned; blk = kk[39:5]; off = kk[4:0].
- Address: mem_rd_addr = cfg_bwt_base + (blk << 5), truncated to ADDR_W.
- IDLE: req_ready=1. On accept, register tag, blk and off.
  - k == all-ones -> RESP with rsp_occ = 0; no memory access, no decompressor use.
  - cache_vld and blk == cache_blk -> DEC_START.
  - Otherwise -> RD_ADDR.
- RD_ADDR: mem_rd_valid=1; address held stable until mem_rd_ready -> WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, load cache_data and cache_blk, set cache_vld=1 -> DEC_START.
- DEC_START: dec_start=1 only while dec_busy=0, so the pulse lasts exactly one cycle.
  - dec_block = cache_data and dec_i = off, both registered.
  - dec_block and dec_i stay stable from DEC_START until the transaction returns to IDLE.
  - Next state: DEC_WAIT.
- DEC_WAIT: on dec_finish, capture dec_val into rsp_occ that same edge -> RESP.
- RESP: rsp_valid=1; rsp_occ and rsp_tag held until rsp_ready. On handshake -> IDLE; req_ready rises the following cycle. There is no request/response overlap.
- Cache:
  - cache_inv clears cache_vld in any state.
  - If cache_inv coincides with a WAIT_RSP fill, invalidation wins, but the current transaction still uses the fetched data.
  - cfg changes require cache_inv.
- Latency, accept edge to rsp_valid:
  - -1 bypass: 1 cycle.
  - Cache hit: 1 + 1 (start) + (off+1) counting + 1 finish.
  - Miss: adds the address handshake plus memory latency.
- off = 31: decompressor counts all 32 symbols. The block does not special-case it.

Decomposition:
- Shared package (BwaMemDefines) holds:
  - OCC_BLK_BYTES=32 and OCC_BLK_SHIFT=5.
  - Typedef occ_cnt_t (40-bit) and occ4_t (array of 4 occ_cnt_t).
  - FSM state enum occ_fetch_state_e.
- Sub-module occ_blk_cache1: one-entry tag/data register with fill, lookup and invalidate.
- The decompressor is instantiated beside this block by the parent, not inside it.

Test Plan:
- req_k=all-ones, tag=0x11 -> rsp_valid 1 cycle after accept, rsp_occ={0,0,0,0}, tag 0x11, no mem_rd_valid.
- cfg_primary=100, req_k=100, base=0x1000 -> kk=99, mem_rd_addr=0x1060 (blk 3), dec_i=3.
  - Memory returns block with counts {10,20,30,40} and symbols 0..3 = A,C,A,T.
  - Expect rsp_occ={12,21,30,41}.
- Back-to-back req_k=64 then req_k=70 (primary=1000) -> second is a cache hit: exactly one mem_rd_valid transaction, dec_i=6 on the second.
- mem_rd_ready held low 5 cycles -> mem_rd_addr stable throughout; one handshake only. rsp_ready low 4 cycles -> rsp_occ and rsp_tag held; req_ready=0 throughout.
- cache_inv pulsed between two same-block requests -> second request refetches, giving 2 memory reads total.
- rst_n asserted during DEC_WAIT -> all outputs reach reset values immediately; after release, a new request completes correctly with no stale response.

Source files
------------

// File: rtl/occ_block_fetch_pkg.sv
// BwaMemDefines: shared definitions for the occurrence-block fetch path.
//   - occurrence block geometry (32-byte blocks, 5-bit in-block offset)
//   - count types for single and four-symbol (A,C,G,T) occurrence counts
//   - fetch FSM state encoding
//   - primary-index adjustment helper
package BwaMemDefines;

  localparam int unsigned OCC_BLK_BYTES = 32;
  localparam int unsigned OCC_BLK_SHIFT = 5;
  localparam int unsigned OCC_BLK_BITS  = 256;
  localparam int unsigned OCC_CNT_W     = 40;
  localparam int unsigned OCC_BLK_IDX_W = OCC_CNT_W - OCC_BLK_SHIFT;

  typedef logic [OCC_CNT_W-1:0]            occ_cnt_t;
  typedef logic [3:0][OCC_CNT_W-1:0]       occ4_t;
  typedef logic [OCC_BLK_IDX_W-1:0]        occ_blk_idx_t;
  typedef logic [OCC_BLK_BITS-1:0]         occ_blk_data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_WAIT_RSP,
    ST_DEC_START,
    ST_DEC_WAIT,
    ST_RESP
  } occ_fetch_state_e;

  // The primary row is not stored in the BWT, so positions at or past it
  // shift down by one.
  function automatic occ_cnt_t occ_adjust_k(occ_cnt_t k, occ_cnt_t primary);
    return k - occ_cnt_t'(k >= primary);
  endfunction

endpackage

// File: rtl/occ_block_fetch_cache1.sv
// occ_blk_cache1: one-entry occurrence block cache.
//   clk, rst_n    clock, async active-low reset
//   inv_i         invalidate (wins over a same-cycle fill)
//   fill_i        write fill_blk_i / fill_data_i and mark valid
//   lookup_blk_i  block index to look up
//   hit_o         valid entry whose block index matches lookup_blk_i
//   data_o        stored block data (independent of valid)
module occ_blk_cache1
  import BwaMemDefines::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inv_i,
  input  logic          fill_i,
  input  occ_blk_idx_t  fill_blk_i,
  input  occ_blk_data_t fill_data_i,
  input  occ_blk_idx_t  lookup_blk_i,
  output logic          hit_o,
  output occ_blk_data_t data_o
);

  logic          vld_q;
  occ_blk_idx_t  blk_q;
  occ_blk_data_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      blk_q  <= '0;
      data_q <= '0;
    end else begin
      if (fill_i) begin
        vld_q  <= 1'b1;
        blk_q  <= fill_blk_i;
        data_q <= fill_data_i;
      end
      // Data is still written on a colliding invalidate; only validity drops.
      if (inv_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign hit_o  = vld_q && (blk_q == lookup_blk_i);
  assign data_o = data_q;

endmodule

// File: rtl/occ_block_fetch.sv
// occ_block_fetch: upstream feeder for the occurrence decompressor.
// Takes a BWT position k, applies the primary-index adjustment, fetches the
// 32-byte occurrence block (or reuses the cached one), drives the external
// decompressor with block + in-block offset and returns the four counts.
//   cfg_primary, cfg_bwt_base, cache_inv   configuration / cache control
//   req_valid/req_ready/req_k/req_tag       request channel (k = all-ones is -1)
//   mem_rd_valid/mem_rd_ready/mem_rd_addr   memory read-address channel
//   mem_rsp_valid/mem_rsp_data              memory read data (no backpressure)
//   dec_block/dec_i/dec_start/dec_busy/
//   dec_finish/dec_val                      decompressor interface
//   rsp_valid/rsp_ready/rsp_occ/rsp_tag     result channel
module occ_block_fetch
  import BwaMemDefines::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [39:0]       cfg_primary,
  input  logic [ADDR_W-1:0] cfg_bwt_base,
  input  logic              cache_inv,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [39:0]       req_k,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [255:0]      mem_rsp_data,
  output logic [255:0]      dec_block,
  output logic [4:0]        dec_i,
  output logic              dec_start,
  input  logic              dec_busy,
  input  logic              dec_finish,
  input  logic [3:0][39:0]  dec_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0][39:0]  rsp_occ,
  output logic [TAG_W-1:0]  rsp_tag
);

  occ_fetch_state_e  state_q;
  logic              req_ready_q;
  logic              mem_rd_valid_q;
  logic [ADDR_W-1:0] mem_rd_addr_q;
  occ_blk_data_t     dec_block_q;
  logic [4:0]        dec_i_q;
  logic              dec_start_q;
  logic              rsp_valid_q;
  occ4_t             rsp_occ_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  occ_blk_idx_t      blk_q;

  occ_cnt_t          kk_d;
  occ_blk_idx_t      blk_d;
  logic [4:0]        off_d;
  logic [ADDR_W-1:0] addr_d;
  logic              k_neg_d;
  logic              accept;
  logic              cache_hit;
  logic              cache_fill;
  occ_blk_data_t     cache_data;

  always_comb begin
    kk_d    = occ_adjust_k(req_k, cfg_primary);
    blk_d   = kk_d[OCC_CNT_W-1:OCC_BLK_SHIFT];
    off_d   = kk_d[OCC_BLK_SHIFT-1:0];
    addr_d  = cfg_bwt_base + ADDR_W'({blk_d, {OCC_BLK_SHIFT{1'b0}}});
    k_neg_d = &req_k;
  end

  assign accept     = req_valid && req_ready_q;
  assign cache_fill = (state_q == ST_WAIT_RSP) && mem_rsp_valid;

  occ_blk_cache1 u_cache (
    .clk          (clk),
    .rst_n        (rst_n),
    .inv_i        (cache_inv),
    .fill_i       (cache_fill),
    .fill_blk_i   (blk_q),
    .fill_data_i  (mem_rsp_data),
    .lookup_blk_i (blk_d),
    .hit_o        (cache_hit),
    .data_o       (cache_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b0;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q  <= '0;
      dec_block_q    <= '0;
      dec_i_q        <= '0;
      dec_start_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_occ_q      <= '0;
      rsp_tag_q      <= '0;
      blk_q          <= '0;
    end else begin
      dec_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            rsp_tag_q   <= req_tag;
            if (k_neg_d) begin
              rsp_occ_q   <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              blk_q   <= blk_d;
              dec_i_q <= off_d;
              if (cache_hit) begin
                dec_block_q <= cache_data;
                state_q     <= ST_DEC_START;
              end else begin
                mem_rd_addr_q  <= addr_d;
                mem_rd_valid_q <= 1'b1;
                state_q        <= ST_RD_ADDR;
              end
            end
          end
        end
        ST_RD_ADDR: begin
          if (mem_rd_ready) begin
            mem_rd_valid_q <= 1'b0;
            state_q        <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          // Load straight from memory so a colliding invalidate cannot
          // starve the transaction that caused the fill.
          if (mem_rsp_valid) begin
            dec_block_q <= mem_rsp_data;
            state_q     <= ST_DEC_START;
          end
        end
        ST_DEC_START: begin
          if (!dec_busy) begin
            dec_start_q <= 1'b1;
            state_q     <= ST_DEC_WAIT;
          end
        end
        ST_DEC_WAIT: begin
          if (dec_finish) begin
            rsp_occ_q   <= dec_val;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign mem_rd_valid = mem_rd_valid_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign dec_block    = dec_block_q;
  assign dec_i        = dec_i_q;
  assign dec_start    = dec_start_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_occ      = rsp_occ_q;
  assign rsp_tag      = rsp_tag_q;

endmodule
